sys_array_feeder: RTL and testbench
===================================

SYS_ARRAY_FEEDER -- requirements
Module: sys_array_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of one data element.
REQ-002 SHALL have parameter ARRAY_A_W, default 4: number of output lanes, equal to the number of array columns.
REQ-003 SHALL have parameter ARRAY_A_L, default 4: number of elements streamed per lane.
REQ-004 SHALL have port clk  input  1: single clock; all logic on the rising edge.
REQ-005 SHALL have port reset_n  input  1: reset, synchronous and active-low.
REQ-006 SHALL have port start  input  1: request to begin one feed transaction.
REQ-007 SHALL have port data_matrix  input  [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]: source matrix, indexed [lane][element].
REQ-008 SHALL have port ready  output  1: high in IDLE only.
REQ-009 SHALL have port weights_load  output  1: weight-load strobe to the array.
REQ-010 SHALL have port input_data  output  [0:ARRAY_A_W-1][DATA_WIDTH-1:0]: skewed lane data to the array.
REQ-011 SHALL have port out_valid  output  1: high on every FEED cycle.
REQ-012 SHALL have port done  output  1: one-cycle pulse at transaction end.

Function
REQ-013 SHALL implement states IDLE, LOAD_W, FEED and DONE; LOAD_W exists only per REQ-025.
REQ-014 SHALL sample start only in IDLE; a start seen in any other state SHALL be ignored and SHALL NOT be queued.
REQ-015 SHALL, on accepting start, register data_matrix into an internal buffer on that same edge; later changes to data_matrix SHALL NOT affect the running transaction.
REQ-016 SHALL stay in FEED for exactly ARRAY_A_L+ARRAY_A_W-1 cycles, tracked by a feed counter t running 0..ARRAY_A_L+ARRAY_A_W-2.
REQ-017 SHALL, in FEED cycle t, drive input_data[k] = buffer[k][t-k] when 0 <= t-k < ARRAY_A_L, and 0 otherwise (lane k lags lane 0 by k cycles).
REQ-018 SHALL register input_data, out_valid, weights_load and done, so each changes on the clock edge that enters the corresponding state.
REQ-019 SHALL drive input_data to all zeros in every state other than FEED.
REQ-020 SHALL move from FEED to DONE after the last feed cycle, assert done for exactly one cycle in DONE, then return to IDLE with ready=1.
REQ-021 SHALL accept a start asserted on the first cycle back in IDLE, giving back-to-back transactions separated only by the DONE and IDLE cycles.
REQ-022 SHALL require ARRAY_A_W >= 1 and ARRAY_A_L >= 1; with ARRAY_A_W=1, FEED lasts ARRAY_A_L cycles and there is no skew.

Reset
REQ-023 SHALL, while reset_n=0 at a clock edge, enter IDLE and clear the feed counter and buffer; on the following cycle ready=1 and weights_load=0, input_data=0, out_valid=0, done=0.
REQ-024 SHALL treat reset in mid-transaction (LOAD_W, FEED or DONE) as an abort: no done pulse, outputs zeroed per REQ-023, and no resume after reset is released.

Configuration
REQ-025 SHALL, when macro SYS_ARRAY_FEEDER_WLOAD_EN is defined, insert state LOAD_W between IDLE and FEED: weights_load=1 for exactly one cycle, then FEED begins on the next cycle.
REQ-026 SHALL, when SYS_ARRAY_FEEDER_WLOAD_EN is undefined, omit LOAD_W, tie weights_load to 0, and go directly from IDLE to FEED on accepted start.

Verification
REQ-027 SHALL cover: defaults, macro undefined, data_matrix[k][s]=16*k+s+1, start for 1 cycle -> 7 FEED cycles; lane0 = 1,2,3,4,0,0,0; lane3 = 0,0,0,49,50,51,52; then a done pulse and ready=1.
REQ-028 SHALL cover: macro defined, same stimulus -> weights_load=1 for exactly 1 cycle, out_valid rising on the next cycle, and identical lane data.
REQ-029 SHALL cover: start held high throughout, plus data_matrix changed during FEED -> no restart before DONE, streamed data equals the values captured at start, and a second transaction begins on the first IDLE cycle.
REQ-030 SHALL cover: reset_n=0 during FEED cycle t=3 -> next cycle all outputs zero and ready=1, no done pulse, and a fresh start then completes normally.
REQ-031 SHALL cover: ARRAY_A_W=1, ARRAY_A_L=3, matrix 5,6,7 -> input_data[0] = 5,6,7 over 3 FEED cycles, then a done pulse.

Source files
------------

// File: rtl/sys_array_feeder.sv
// sys_array_feeder: captures a [lane][element] matrix on start and streams it
// to a systolic array with a one-cycle skew per lane.
// Optional feature: define SYS_ARRAY_FEEDER_WLOAD_EN to add a one-cycle
// weight-load phase (LOAD_W) between IDLE and FEED.
//
// state  | meaning
// IDLE   | ready=1, waiting for start; matrix captured on the accepting edge
// LOAD_W | weights_load strobe for one cycle (only with WLOAD_EN)
// FEED   | skewed lane data streamed, cnt_q = t in 0..L+W-2
// DONE   | one-cycle done pulse, then back to IDLE
module sys_array_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_A_W  = 4,
  parameter int ARRAY_A_L  = 4
) (
  input  logic                                                  clk,
  input  logic                                                  reset_n,
  input  logic                                                  start,
  input  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0]   data_matrix,
  output logic                                                  ready,
  output logic                                                  weights_load,
  output logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0]                  input_data,
  output logic                                                  out_valid,
  output logic                                                  done
);

  localparam int FEED_LEN = ARRAY_A_L + ARRAY_A_W - 1;
  localparam int CW       = $clog2(FEED_LEN + 1);
  localparam logic [CW-1:0] FEED_LAST = CW'(FEED_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    FEED   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:ARRAY_A_W-1][0:ARRAY_A_L-1][DATA_WIDTH-1:0] buf_q, buf_d;
  logic [0:ARRAY_A_W-1][DATA_WIDTH-1:0] data_q, data_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
  logic wload_q, wload_d;
`endif

  // Next state, counter, capture buffer and the control outputs of the next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
    wload_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          buf_d = data_matrix;
          cnt_d = '0;
`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
          state_d = LOAD_W;
          wload_d = 1'b1;
`else
          state_d = FEED;
          valid_d = 1'b1;
`endif
        end
      end
`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
      LOAD_W: begin
        state_d = FEED;
        cnt_d   = '0;
        valid_d = 1'b1;
      end
`endif
      FEED: begin
        if (cnt_q == FEED_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          valid_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Skewed lane data for the next cycle: lane k carries element t-k while it exists.
  always_comb begin
    data_d = '0;
    if (state_d == FEED) begin
      for (int k = 0; k < ARRAY_A_W; k++) begin
        for (int s = 0; s < ARRAY_A_L; s++) begin
          if (int'(cnt_d) == k + s) data_d[k] = buf_d[k][s];
        end
      end
    end
  end

  // State and registered outputs; a reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
  // Weight-load strobe register.
  always_ff @(posedge clk) begin
    if (!reset_n) wload_q <= 1'b0;
    else          wload_q <= wload_d;
  end
  assign weights_load = wload_q;
`else
  assign weights_load = 1'b0;
`endif

  assign ready      = (state_q == IDLE);
  assign input_data = data_q;
  assign out_valid  = valid_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sys_array_feeder.sv
// Bench for sys_array_feeder: a 4x4 instance and a 1x3 instance, each checked
// every cycle against a transaction-level model (output = f(cycles since accept)).
module tb_sys_array_feeder;

`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
  localparam int WL = 1;
`else
  localparam int WL = 0;
`endif
  localparam int LEN_A = WL + 7 + 1;
  localparam int LEN_B = WL + 3 + 1;

  typedef logic [7:0] mat_t [4][4];
  typedef struct {
    logic       wl;
    logic       valid;
    logic       done;
    logic       ready;
    logic [7:0] data [4];
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic [0:3][0:3][7:0] dm_a = '0;
  logic [0:0][0:2][7:0] dm_b = '0;

  logic ready_a, wl_a, valid_a, done_a;
  logic [0:3][7:0] data_a;
  logic ready_b, wl_b, valid_b, done_b;
  logic [0:0][7:0] data_b;

  sys_array_feeder #(.DATA_WIDTH(8), .ARRAY_A_W(4), .ARRAY_A_L(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .data_matrix(dm_a),
    .ready(ready_a), .weights_load(wl_a), .input_data(data_a),
    .out_valid(valid_a), .done(done_a)
  );

  sys_array_feeder #(.DATA_WIDTH(8), .ARRAY_A_W(1), .ARRAY_A_L(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .data_matrix(dm_b),
    .ready(ready_b), .weights_load(wl_b), .input_data(data_b),
    .out_valid(valid_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outputs at a given position of a transaction (-1 = idle).
  function automatic rec_t exp_rec(input int pos, input int w, input int l, input mat_t m);
    rec_t r;
    int p;
    r.wl = 0; r.valid = 0; r.done = 0; r.ready = 0;
    for (int k = 0; k < 4; k++) r.data[k] = 8'd0;
    if (pos < 0) begin
      r.ready = 1;
    end else begin
      p = pos;
      if (WL != 0) begin
        if (p == 0) r.wl = 1;
        p = p - 1;
      end
      if (p >= 0 && p < l + w - 1) begin
        r.valid = 1;
        for (int k = 0; k < w; k++)
          for (int s = 0; s < l; s++)
            if (p == k + s) r.data[k] = m[k][s];
      end else if (p == l + w - 1) begin
        r.done = 1;
      end
    end
    return r;
  endfunction

  // Transaction model: position since accept, captured matrix.
  int   pa = -1, pb = -1;
  mat_t ma, mb;
  bit   chk_en = 0;
  rec_t ea, eb;

  always @(posedge clk) begin
    if (!reset_n) begin
      pa <= -1;
      pb <= -1;
      chk_en <= 1;
    end else begin
      if (pa < 0) begin
        if (start_a) begin
          pa <= 0;
          for (int k = 0; k < 4; k++)
            for (int s = 0; s < 4; s++) ma[k][s] <= dm_a[k][s];
        end
      end else if (pa < LEN_A - 1) pa <= pa + 1;
      else pa <= -1;
      if (pb < 0) begin
        if (start_b) begin
          pb <= 0;
          for (int k = 0; k < 4; k++)
            for (int s = 0; s < 4; s++) mb[k][s] <= (k == 0 && s < 3) ? dm_b[0][s] : 8'd0;
        end
      end else if (pb < LEN_B - 1) pb <= pb + 1;
      else pb <= -1;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      ea = exp_rec(pa, 4, 4, ma);
      chk("a_ready", ready_a, ea.ready);
      chk("a_wload", wl_a, ea.wl);
      chk("a_valid", valid_a, ea.valid);
      chk("a_done", done_a, ea.done);
      for (int k = 0; k < 4; k++) chk($sformatf("a_lane%0d", k), data_a[k], ea.data[k]);
      eb = exp_rec(pb, 1, 3, mb);
      chk("b_ready", ready_b, eb.ready);
      chk("b_wload", wl_b, eb.wl);
      chk("b_valid", valid_b, eb.valid);
      chk("b_done", done_b, eb.done);
      chk("b_lane0", data_b[0], eb.data[0]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_a(input int mul, input int off);
    for (int k = 0; k < 4; k++)
      for (int s = 0; s < 4; s++) dm_a[k][s] = 8'(mul * k + s + off);
  endtask

  task automatic wait_valid_a(input string nm);
    int n = 0;
    while (!valid_a && n < 20) begin step(1); n++; end
    chk(nm, valid_a, 1'b1);
  endtask

  task automatic wait_done_a(input string nm);
    int n = 0;
    while (!done_a && n < 30) begin step(1); n++; end
    chk(nm, done_a, 1'b1);
  endtask

  logic [7:0] exp_l0 [7] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0};
  logic [7:0] exp_l3 [7] = '{8'd0, 8'd0, 8'd0, 8'd49, 8'd50, 8'd51, 8'd52};
  logic [7:0] exp_b  [3] = '{8'd5, 8'd6, 8'd7};

  initial begin
    dm_b[0][0] = 8'd5; dm_b[0][1] = 8'd6; dm_b[0][2] = 8'd7;
    step(2);
    reset_n = 1'b1;
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_valid", valid_a, 1'b0);
    chk("rst_data", data_a, '0);

    // Basic transaction on both instances.
    fill_a(16, 1);
    start_a = 1'b1; start_b = 1'b1;
    step(1);
    start_a = 1'b0; start_b = 1'b0;
`ifdef SYS_ARRAY_FEEDER_WLOAD_EN
    chk("lit_wload_on", wl_a, 1'b1);
    chk("lit_wload_novalid", valid_a, 1'b0);
    step(1);
    chk("lit_wload_off", wl_a, 1'b0);
`endif
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("lit_valid_t%0d", i), valid_a, 1'b1);
      chk($sformatf("lit_lane0_t%0d", i), data_a[0], exp_l0[i]);
      chk($sformatf("lit_lane3_t%0d", i), data_a[3], exp_l3[i]);
      if (i < 3) chk($sformatf("lit_b_t%0d", i), data_b[0], exp_b[i]);
      if (i == 3) chk("lit_b_done", done_b, 1'b1);
      step(1);
    end
    chk("lit_done", done_a, 1'b1);
    chk("lit_done_ready", ready_a, 1'b0);
    step(1);
    chk("lit_idle_ready", ready_a, 1'b1);
    chk("lit_idle_done", done_a, 1'b0);

    // Start held high, matrix changed mid-feed, back-to-back restart.
    fill_a(3, 7);
    start_a = 1'b1;
    wait_valid_a("c_valid_timeout");
    step(2);
    fill_a(5, 100);
    wait_done_a("c_done_timeout");
    step(1);
    chk("c_idle_ready", ready_a, 1'b1);
    step(1);
    if (WL != 0) chk("c_restart", wl_a, 1'b1);
    else chk("c_restart", valid_a, 1'b1);
    wait_done_a("c_done2_timeout");
    start_a = 1'b0;
    step(3);

    // Reset during FEED t=3, then a fresh run with an ignored mid-feed start.
    fill_a(2, 9);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_valid_a("d_valid_timeout");
    step(3);
    reset_n = 1'b0;
    step(1);
    chk("d_rst_ready", ready_a, 1'b1);
    chk("d_rst_valid", valid_a, 1'b0);
    chk("d_rst_done", done_a, 1'b0);
    chk("d_rst_data", data_a, '0);
    reset_n = 1'b1;
    step(6);
    chk("d_no_resume", valid_a, 1'b0);
    fill_a(1, 0);
    start_a = 1'b1;
    step(1);
    start_a = 1'b0;
    wait_valid_a("e_valid_timeout");
    step(2);
    start_a = 1'b1;
    step(2);
    start_a = 1'b0;
    wait_done_a("e_done_timeout");
    step(2);
    chk("e_no_queue_ready", ready_a, 1'b1);
    chk("e_no_queue_busy", valid_a | wl_a, 1'b0);
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
